proc_trace_buffer: RTL and testbench

PROC_TRACE_BUFFER -- requirements
Module: proc_trace_buffer

---
 rtl/proc_trace_pkg.sv | 13 +
 rtl/trace_fifo.sv | 58 +++++
 rtl/proc_trace_buffer.sv | 79 +++++++
 tb/tb_proc_trace_buffer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/proc_trace_pkg.sv
// Shared constants and the captured trace record layout for the trace buffer.
package proc_trace_pkg;

  localparam int TRACE_W = 32;
  localparam int SEQ_W   = 8;

  typedef struct packed {
    logic [SEQ_W-1:0]   seq;
    logic [TRACE_W-1:0] addr;
    logic [TRACE_W-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// First-word fall-through FIFO: head entry is read combinationally from
// registered storage, so a write at edge N is visible on rd_entry in cycle N+1.
module trace_fifo
  import proc_trace_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = trace_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  entry_t                 wr_entry,
  input  logic                   pop,
  output entry_t                 rd_entry,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push  = push && (!full || do_pop);
  assign rd_entry = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset; it is unobservable while empty.
  always_ff @(posedge clk) begin
    if (rst && !clear && do_push) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/proc_trace_buffer.sv
// Processor trace capture: tags each captured event with a rolling sequence
// number, buffers it for a drain consumer and counts events lost to overflow.
module proc_trace_buffer
  import proc_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int OVF_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   trace_val,
  input  logic [TRACE_W-1:0]     trace_addr,
  input  logic [TRACE_W-1:0]     trace_data,
  input  logic                   cap_en,
  input  logic                   clear,
  output logic                   drain_val,
  input  logic                   drain_rdy,
  output logic [SEQ_W-1:0]       drain_seq,
  output logic [TRACE_W-1:0]     drain_addr,
  output logic [TRACE_W-1:0]     drain_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic [OVF_W-1:0]       ovf_cnt
);

  // Drain handshake: an entry transfers on every rising edge where
  // drain_val && drain_rdy; drain_val never depends on drain_rdy, and the
  // presented entry holds steady while drain_val is high and drain_rdy low.

  logic               trace_evt;
  logic               pop;
  logic               push;
  logic               drop;
  logic [SEQ_W-1:0]   seq;
  trace_entry_t       wr_entry;
  trace_entry_t       head;

  assign trace_evt = trace_val && cap_en;
  assign pop       = drain_val && drain_rdy;
  assign push      = trace_evt && (!full || pop);
  assign drop      = trace_evt && full && !pop;

  assign wr_entry  = '{seq: seq, addr: trace_addr, data: trace_data};

  trace_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (trace_entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .push     (push),
    .wr_entry (wr_entry),
    .pop      (pop),
    .rd_entry (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  assign drain_val  = !empty;
  assign drain_seq  = head.seq;
  assign drain_addr = head.addr;
  assign drain_data = head.data;

  // Sequence advances on every event, stored or dropped, so gaps in the
  // drained tags reveal where overflow occurred.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      seq     <= '0;
      ovf_cnt <= '0;
    end else begin
      if (trace_evt) seq <= seq + SEQ_W'(1);
      if (drop && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + OVF_W'(1);
    end
  end

endmodule

// File: tb/tb_proc_trace_buffer.sv
// Bench for proc_trace_buffer: table-driven fill/overflow vectors, directed
// sequences for reset/clear/wrap, and a scoreboard of expected drain entries.
module tb_proc_trace_buffer;

  localparam int DEPTH = 8;
  localparam int OVF_W = 16;

  logic        clk;
  logic        rst;
  logic        trace_val;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic        cap_en;
  logic        clear;
  logic        drain_val;
  logic        drain_rdy;
  logic [7:0]  drain_seq;
  logic [31:0] drain_addr;
  logic [31:0] drain_data;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic [15:0] ovf_cnt;

  proc_trace_buffer #(.DEPTH(DEPTH), .OVF_W(OVF_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .trace_val  (trace_val),
    .trace_addr (trace_addr),
    .trace_data (trace_data),
    .cap_en     (cap_en),
    .clear      (clear),
    .drain_val  (drain_val),
    .drain_rdy  (drain_rdy),
    .drain_seq  (drain_seq),
    .drain_addr (drain_addr),
    .drain_data (drain_data),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .ovf_cnt    (ovf_cnt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [71:0] exp_q[$];
  int          m_count;
  logic [7:0]  m_seq;
  int          m_ovf;
  int          n_cmp;
  int          n_err;

  typedef struct {
    logic        tv;
    logic        ce;
    logic        rdy;
    logic [31:0] addr;
    logic [31:0] data;
    int          exp_count;
    int          exp_ovf;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic tv, input logic ce, input logic rdy,
                       input logic [31:0] addr, input logic [31:0] data);
    trace_val  = tv;
    cap_en     = ce;
    drain_rdy  = rdy;
    trace_addr = addr;
    trace_data = data;
  endtask

  // Model the coming edge from the inputs, compare the head, then clock and
  // compare the status outputs against the model.
  task automatic step();
    logic        m_pop;
    logic [71:0] head;
    @(negedge clk);
    check("drain_val", {71'd0, drain_val}, {71'd0, (m_count > 0)});
    m_pop = (m_count > 0) && drain_rdy;
    if (m_count > 0 && exp_q.size() > 0) begin
      head = exp_q[0];
      check("drain_entry", {drain_seq, drain_addr, drain_data}, head);
    end
    if (!rst || clear) begin
      exp_q.delete();
      m_count = 0;
      m_seq   = 8'd0;
      m_ovf   = 0;
    end else begin
      if (m_pop) begin
        void'(exp_q.pop_front());
        m_count--;
      end
      if (trace_val && cap_en) begin
        if (m_count < DEPTH) begin
          exp_q.push_back({m_seq, trace_addr, trace_data});
          m_count++;
        end else if (m_ovf < 65535) begin
          m_ovf++;
        end
        m_seq = m_seq + 8'd1;
      end
    end
    @(posedge clk);
    #1;
    check("count", {68'd0, count}, 72'(m_count));
    check("full",  {71'd0, full},  {71'd0, (m_count == DEPTH)});
    check("empty", {71'd0, empty}, {71'd0, (m_count == 0)});
    check("ovf_cnt", {56'd0, ovf_cnt}, 72'(m_ovf));
  endtask

  task automatic drain_all();
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (m_count == 0) break;
      drive(1'b0, 1'b1, 1'b1, 32'd0, 32'd0);
      step();
    end
    check("drain_all_empty", {71'd0, empty}, 72'd1);
  endtask

  task automatic do_clear();
    drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    m_count = 0; m_seq = 8'd0; m_ovf = 0;
    rst = 1'b0; clear = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // reset state
    step(); step();
    check("rst_drain_val", {71'd0, drain_val}, 72'd0);
    check("rst_count", {68'd0, count}, 72'd0);
    rst = 1'b1;

    // three events held, then drained in order
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'hA + 32'(i));
      step();
    end
    check("three_count", {68'd0, count}, 72'd3);
    check("three_head_seq", {64'd0, drain_seq}, 72'd0);
    drain_all();

    // table: fill past full, push-with-pop on full, cap_en gating
    for (int i = 0; i < 10; i++)
      vecs[i] = '{1'b1, 1'b1, 1'b0, 32'h2000 + 32'(i), 32'h5000 + 32'(i),
                  (i < 8) ? i + 1 : 8, (i < 8) ? 0 : i - 7};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 32'h3000, 32'h6000, 8, 2};
    for (int i = 11; i < 16; i++)
      vecs[i] = '{1'b1, 1'b0, 1'b0, 32'hDEAD, 32'hBEEF, 8, 2};
    do_clear();
    foreach (vecs[i]) begin
      drive(vecs[i].tv, vecs[i].ce, vecs[i].rdy, vecs[i].addr, vecs[i].data);
      step();
      check("vec_count", {68'd0, count}, 72'(vecs[i].exp_count));
      check("vec_ovf", {56'd0, ovf_cnt}, 72'(vecs[i].exp_ovf));
    end
    check("vec_full", {71'd0, full}, 72'd1);
    drain_all();
    // seq was 11 after the gated cycles; next event must carry it
    drive(1'b1, 1'b1, 1'b0, 32'h44, 32'h55);
    step();
    check("gated_seq", {64'd0, drain_seq}, 72'd11);

    // 300 events with drain_rdy held: tag wraps, never full
    do_clear();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b1, 1'b1, $urandom, $urandom);
      step();
      if (i == 256) check("wrap_seq", {64'd0, drain_seq}, 72'd0);
    end
    check("stream_ovf", {56'd0, ovf_cnt}, 72'd0);
    drain_all();

    // reset mid-operation with a concurrent event
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h700 + 32'(i), 32'h800 + 32'(i));
      step();
    end
    drive(1'b1, 1'b1, 1'b1, 32'h999, 32'h999);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("rst_mid_empty", {71'd0, empty}, 72'd1);
    drive(1'b1, 1'b1, 1'b0, 32'hAB, 32'hCD);
    step();
    check("rst_mid_seq", {64'd0, drain_seq}, 72'd0);
    drain_all();

    // clear with overflow pending and a concurrent event
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h900 + 32'(i), 32'h1 + 32'(i));
      step();
    end
    drive(1'b1, 1'b1, 1'b1, 32'h999, 32'h999);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_empty", {71'd0, empty}, 72'd1);
    check("clr_ovf", {56'd0, ovf_cnt}, 72'd0);
    drive(1'b1, 1'b1, 1'b0, 32'hAB, 32'hCD);
    step();
    check("clr_seq", {64'd0, drain_seq}, 72'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0),
            1'($urandom_range(0, 2) == 0), $urandom, $urandom);
      step();
    end
    drain_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
